store_unit: RTL and testbench

Store-side data-memory interface for the STRV32I core, the write counterpart of the load unit. It accepts one store per handshake from the execute stage and steers `rs2` data into the correct byte lanes. It generates the byte write mask and word-aligned address, then holds a registered write request on the data-memory port until the memory acknowledges it. Back-to-back stores are supported: a new store is accepted in the same cycle the current one is acknowledged. A bounded wait timeout reports a bus error.

---
 rtl/store_unit.sv | 205 ++++++++++++++++++++
 tb/tb_store_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/store_unit.sv
// -----------------------------------------------------------------------------
// store_unit
//
// Store-side data-memory interface for the STRV32I core. Accepts one store per
// valid/ready handshake from the execute stage, steers rs2 into the addressed
// byte lanes, builds the byte write mask and word-aligned address, and holds a
// registered write request on the data-memory port until it is acknowledged.
// A new store can be accepted in the same cycle the current one completes,
// giving one store per cycle while the memory stays ready. A pending write
// that sees TIMEOUT_CYCLES consecutive not-ready cycles is dropped and a
// one-cycle bus error pulse is raised.
//
// Optional feature macro: STORE_MISALIGN_TRAP_EN
//   defined   : misaligned half/word stores are accepted but not issued, and
//               misaligned_out pulses one cycle after the accept edge.
//   undefined : misaligned_out is absent; low address bits below the access
//               size are ignored.
//
// Parameters:
//   TIMEOUT_CYCLES  consecutive not-ready PEND cycles before a write is
//                   abandoned (0 disables the timeout)
//
// Ports:
//   clk_in           core clock, rising edge
//   rst_n_in         asynchronous active-low reset
//   store_valid_in   execute stage presents a store
//   store_size_in    00 byte, 01 half, 10/11 word
//   iadder_in        effective byte address
//   rs2_in           store data, LSB-justified
//   store_ready_out  store accepted when high together with store_valid_in
//   dmem_ready_in    memory accepts the presented write this cycle
//   dmem_wr_req_out  write request valid
//   dmem_addr_out    word-aligned address of the held store
//   dmem_wdata_out   lane-replicated write data
//   dmem_wmask_out   byte enables (bit n enables wdata[8n+7:8n])
//   bus_error_out    one-cycle pulse when a write is abandoned on timeout
//   misaligned_out   one-cycle pulse on a rejected misaligned store (macro only)
// -----------------------------------------------------------------------------
module store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        store_valid_in,
  input  logic [1:0]  store_size_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs2_in,
  output logic        store_ready_out,
  input  logic        dmem_ready_in,
  output logic        dmem_wr_req_out,
  output logic [31:0] dmem_addr_out,
  output logic [31:0] dmem_wdata_out,
  output logic [3:0]  dmem_wmask_out,
  output logic        bus_error_out
`ifdef STORE_MISALIGN_TRAP_EN
  ,
  output logic        misaligned_out
`endif
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Counter value seen in the last allowed not-ready cycle; the drop happens
  // on the edge that would take the count to TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_error_q, bus_error_d;

  logic [1:0]       lane;
  logic [31:0]      wdata_new;
  logic [3:0]       mask_new;
  logic             accept;
  logic             issue;
  logic             complete;
  logic             timeout_hit;

`ifdef STORE_MISALIGN_TRAP_EN
  logic             misaligned_new;
  logic             misaligned_q, misaligned_d;
`endif

  // ---------------------------------------------------------------------------
  // Lane steering for the incoming store
  // ---------------------------------------------------------------------------
  always_comb begin
    lane      = iadder_in[1:0];
    wdata_new = rs2_in;
    mask_new  = 4'b1111;
    case (store_size_in)
      2'b00: begin
        wdata_new = {4{rs2_in[7:0]}};
        mask_new  = 4'b0001 << lane;
      end
      2'b01: begin
        wdata_new = {2{rs2_in[15:0]}};
        mask_new  = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_new = rs2_in;
        mask_new  = 4'b1111;
      end
    endcase
  end

`ifdef STORE_MISALIGN_TRAP_EN
  assign misaligned_new = ((store_size_in == 2'b01) && lane[0]) ||
                          (store_size_in[1] && (lane != 2'b00));
`endif

  // ---------------------------------------------------------------------------
  // Handshake and control
  // ---------------------------------------------------------------------------
  assign store_ready_out = (state_q == IDLE) || dmem_ready_in;
  assign accept          = store_valid_in && store_ready_out;
  assign complete        = (state_q == PEND) && dmem_ready_in;
  assign timeout_hit     = (TIMEOUT_CYCLES != 0) && (state_q == PEND) &&
                           !dmem_ready_in && (cnt_q == CNT_LAST);

`ifdef STORE_MISALIGN_TRAP_EN
  // A misaligned store is consumed by the handshake but never reaches memory.
  assign issue = accept && !misaligned_new;
`else
  assign issue = accept;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    bus_error_d = timeout_hit;

    if (issue) begin
      state_d = PEND;
      addr_d  = {iadder_in[31:2], 2'b00};
      wdata_d = wdata_new;
      mask_d  = mask_new;
    end else if (complete || timeout_hit) begin
      // Back to IDLE: the mask must read 0000 while nothing is pending.
      state_d = IDLE;
      mask_d  = 4'b0000;
    end

    if (accept || timeout_hit) begin
      cnt_d = '0;
    end else if ((state_q == PEND) && !dmem_ready_in && (TIMEOUT_CYCLES != 0)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

`ifdef STORE_MISALIGN_TRAP_EN
  assign misaligned_d = accept && misaligned_new;
`endif

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      bus_error_q <= bus_error_d;
    end
  end

`ifdef STORE_MISALIGN_TRAP_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misaligned_d;
    end
  end

  assign misaligned_out = misaligned_q;
`endif

  assign dmem_wr_req_out = (state_q == PEND);
  assign dmem_addr_out   = addr_q;
  assign dmem_wdata_out  = wdata_q;
  assign dmem_wmask_out  = mask_q;
  assign bus_error_out   = bus_error_q;

endmodule

// File: tb/tb_store_unit.sv
// -----------------------------------------------------------------------------
// tb_store_unit
//
// Directed bench for store_unit built with TIMEOUT_CYCLES = 4. Inputs are
// driven and outputs observed on the falling clock edge; the DUT samples on
// the rising edge in between.
// -----------------------------------------------------------------------------
module tb_store_unit;

  logic        clk_in;
  logic        rst_n_in;
  logic        store_valid_in;
  logic [1:0]  store_size_in;
  logic [31:0] iadder_in;
  logic [31:0] rs2_in;
  logic        store_ready_out;
  logic        dmem_ready_in;
  logic        dmem_wr_req_out;
  logic [31:0] dmem_addr_out;
  logic [31:0] dmem_wdata_out;
  logic [3:0]  dmem_wmask_out;
  logic        bus_error_out;
`ifdef STORE_MISALIGN_TRAP_EN
  logic        misaligned_out;
`endif

  int checks = 0;
  int errors = 0;

  store_unit #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .store_valid_in  (store_valid_in),
    .store_size_in   (store_size_in),
    .iadder_in       (iadder_in),
    .rs2_in          (rs2_in),
    .store_ready_out (store_ready_out),
    .dmem_ready_in   (dmem_ready_in),
    .dmem_wr_req_out (dmem_wr_req_out),
    .dmem_addr_out   (dmem_addr_out),
    .dmem_wdata_out  (dmem_wdata_out),
    .dmem_wmask_out  (dmem_wmask_out),
    .bus_error_out   (bus_error_out)
`ifdef STORE_MISALIGN_TRAP_EN
    ,
    .misaligned_out  (misaligned_out)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy);
    store_valid_in = v;
    store_size_in  = sz;
    iadder_in      = a;
    rs2_in         = d;
    dmem_ready_in  = rdy;
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask);
    chk({tag, ".req"},   {31'd0, dmem_wr_req_out}, {31'd0, req});
    chk({tag, ".addr"},  dmem_addr_out,  addr);
    chk({tag, ".wdata"}, dmem_wdata_out, wdata);
    chk({tag, ".mask"},  {28'd0, dmem_wmask_out}, {28'd0, mask});
  endtask

  initial begin
    rst_n_in = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);

    // Reset state
    #3;
    chk("rst.req",   {31'd0, dmem_wr_req_out}, 32'd0);
    chk("rst.addr",  dmem_addr_out, 32'd0);
    chk("rst.wdata", dmem_wdata_out, 32'd0);
    chk("rst.mask",  {28'd0, dmem_wmask_out}, 32'd0);
    chk("rst.berr",  {31'd0, bus_error_out}, 32'd0);
    chk("rst.ready", {31'd0, store_ready_out}, 32'd1);
`ifdef STORE_MISALIGN_TRAP_EN
    chk("rst.mis",   {31'd0, misaligned_out}, 32'd0);
`endif
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Ready in IDLE has no effect
    @(negedge clk_in);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    @(negedge clk_in);
    chk("idle.req", {31'd0, dmem_wr_req_out}, 32'd0);
    $display("txn idle-ready: req=%0b", dmem_wr_req_out);

    // Byte store at 0x1003, immediate ready
    drive(1'b1, 2'b00, 32'h0000_1003, 32'h0000_00A5, 1'b1);
    #1 chk("byte.ready", {31'd0, store_ready_out}, 32'd1);
    @(negedge clk_in);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    chk_req("byte", 1'b1, 32'h0000_1000, 32'hA5A5_A5A5, 4'b1000);
    $display("txn byte: addr=%h wdata=%h mask=%b", dmem_addr_out, dmem_wdata_out, dmem_wmask_out);
    @(negedge clk_in);
    chk("byte.done.req",  {31'd0, dmem_wr_req_out}, 32'd0);
    chk("byte.done.mask", {28'd0, dmem_wmask_out}, 32'd0);

    // Half store at 0x2002, ready low for 3 cycles
    drive(1'b1, 2'b01, 32'h0000_2002, 32'h1234_BEEF, 1'b0);
    @(negedge clk_in);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 2'b00, 32'h0, 32'h0, (k == 3));
      #1;
      chk_req($sformatf("half.c%0d", k), 1'b1, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100);
      chk($sformatf("half.c%0d.ready", k), {31'd0, store_ready_out}, {31'd0, (k == 3)});
      $display("txn half cycle %0d: req=%0b mask=%b ready=%0b", k, dmem_wr_req_out,
               dmem_wmask_out, store_ready_out);
      @(negedge clk_in);
    end
    chk("half.done.req", {31'd0, dmem_wr_req_out}, 32'd0);

    // Three back-to-back word stores
    drive(1'b1, 2'b10, 32'h0000_4000, 32'h1111_1111, 1'b1);
    @(negedge clk_in);
    drive(1'b1, 2'b11, 32'h0000_4004, 32'h2222_2222, 1'b1);
    #1 chk("b2b.ready", {31'd0, store_ready_out}, 32'd1);
    chk_req("b2b0", 1'b1, 32'h0000_4000, 32'h1111_1111, 4'b1111);
    $display("txn word0: addr=%h wdata=%h", dmem_addr_out, dmem_wdata_out);
    @(negedge clk_in);
    drive(1'b1, 2'b10, 32'h0000_4008, 32'h3333_3333, 1'b1);
    chk_req("b2b1", 1'b1, 32'h0000_4004, 32'h2222_2222, 4'b1111);
    $display("txn word1: addr=%h wdata=%h", dmem_addr_out, dmem_wdata_out);
    @(negedge clk_in);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    chk_req("b2b2", 1'b1, 32'h0000_4008, 32'h3333_3333, 4'b1111);
    $display("txn word2: addr=%h wdata=%h", dmem_addr_out, dmem_wdata_out);
    @(negedge clk_in);
    chk("b2b.done.req", {31'd0, dmem_wr_req_out}, 32'd0);

    // Timeout: ready never asserted
    drive(1'b1, 2'b10, 32'h0000_5000, 32'h0BAD_F00D, 1'b0);
    @(negedge clk_in);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("tmo.c%0d.req", k),  {31'd0, dmem_wr_req_out}, 32'd1);
      chk($sformatf("tmo.c%0d.berr", k), {31'd0, bus_error_out}, 32'd0);
      @(negedge clk_in);
    end
    chk("tmo.berr",  {31'd0, bus_error_out}, 32'd1);
    chk("tmo.req",   {31'd0, dmem_wr_req_out}, 32'd0);
    chk("tmo.mask",  {28'd0, dmem_wmask_out}, 32'd0);
    chk("tmo.ready", {31'd0, store_ready_out}, 32'd1);
    $display("txn timeout: berr=%0b req=%0b", bus_error_out, dmem_wr_req_out);
    @(negedge clk_in);
    chk("tmo.berr.end", {31'd0, bus_error_out}, 32'd0);

    // Reset while pending
    drive(1'b1, 2'b00, 32'h0000_6001, 32'h0000_005A, 1'b0);
    @(negedge clk_in);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    chk_req("rpend", 1'b1, 32'h0000_6000, 32'h5A5A_5A5A, 4'b0010);
    #2 rst_n_in = 1'b0;
    #1;
    chk("rpend.req.async",  {31'd0, dmem_wr_req_out}, 32'd0);
    chk("rpend.mask.async", {28'd0, dmem_wmask_out}, 32'd0);
    $display("txn reset-in-pend: req=%0b mask=%b", dmem_wr_req_out, dmem_wmask_out);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    chk("rpend.berr", {31'd0, bus_error_out}, 32'd0);
    drive(1'b1, 2'b01, 32'h0000_6000, 32'h0000_CAFE, 1'b1);
    @(negedge clk_in);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    chk_req("rpost", 1'b1, 32'h0000_6000, 32'hCAFE_CAFE, 4'b0011);
    $display("txn post-reset half: addr=%h mask=%b", dmem_addr_out, dmem_wmask_out);
    @(negedge clk_in);
    chk("rpost.done.req", {31'd0, dmem_wr_req_out}, 32'd0);

    // Misaligned word store at 0x3001
    drive(1'b1, 2'b10, 32'h0000_3001, 32'hDEAD_BEEF, 1'b1);
    #1 chk("mis.ready", {31'd0, store_ready_out}, 32'd1);
    @(negedge clk_in);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
`ifdef STORE_MISALIGN_TRAP_EN
    chk("mis.pulse", {31'd0, misaligned_out}, 32'd1);
    chk("mis.req",   {31'd0, dmem_wr_req_out}, 32'd0);
    $display("txn misaligned: mis=%0b req=%0b", misaligned_out, dmem_wr_req_out);
    @(negedge clk_in);
    chk("mis.pulse.end", {31'd0, misaligned_out}, 32'd0);
    chk("mis.req.end",   {31'd0, dmem_wr_req_out}, 32'd0);
`else
    chk_req("mis", 1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 4'b1111);
    $display("txn misaligned word: addr=%h mask=%b", dmem_addr_out, dmem_wmask_out);
    @(negedge clk_in);
    chk("mis.done.req", {31'd0, dmem_wr_req_out}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
